// File: rtl/cpu_defs.sv
// Shared definitions for the sirius fetch path: instruction width, PC stride
// and the layout of one instruction-queue entry.
package cpu_defs;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/inst_fq_ram.sv
// Entry storage for the instruction fetch queue: two write ports for a dual
// fetch beat and two asynchronous read ports for the two oldest entries.
module inst_fq_ram
  import cpu_defs::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_1,
  input  logic [PTR_W-1:0]      waddr_1,
  input  logic [2*INST_W-1:0]   wdata_1,
  input  logic                  we_2,
  input  logic [PTR_W-1:0]      waddr_2,
  input  logic [2*INST_W-1:0]   wdata_2,
  input  logic [PTR_W-1:0]      raddr_1,
  input  logic [PTR_W-1:0]      raddr_2,
  output logic [2*INST_W-1:0]   rdata_1,
  output logic [2*INST_W-1:0]   rdata_2
);

  fq_entry_t mem [DEPTH];

  // The top guarantees waddr_1 != waddr_2 whenever both ports write.
  always_ff @(posedge clk) begin
    if (we_1) mem[waddr_1] <= wdata_1;
    if (we_2) mem[waddr_2] <= wdata_2;
  end

  assign rdata_1 = mem[raddr_1];
  assign rdata_2 = mem[raddr_2];

endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-in / dual-out instruction queue between the MMU fetch port and decode.
// Optional performance counters are built when INST_FETCH_QUEUE_PERF_EN is defined.
module inst_fetch_queue
  import cpu_defs::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_ok_1,
  input  logic              in_ok_2,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_inst_1,
  input  logic [31:0]       in_inst_2,
  output logic              in_ready,
  output logic              out_valid_1,
  output logic              out_valid_2,
  output logic [31:0]       out_pc_1,
  output logic [31:0]       out_pc_2,
  output logic [31:0]       out_inst_1,
  output logic [31:0]       out_inst_2,
  input  logic [1:0]        deq_num,
  output logic [PTR_W:0]    count
`ifdef INST_FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]       perf_full_cycles,
  output logic [31:0]       perf_empty_cycles
`endif
);

  logic [PTR_W-1:0]    wptr;
  logic [PTR_W-1:0]    rptr;
  logic                enq;
  logic                enq_2;
  logic [1:0]          enq_n;
  logic [1:0]          deq_req;
  logic [1:0]          deq_eff;
  logic [2*INST_W-1:0] rdata_1;
  logic [2*INST_W-1:0] rdata_2;
  fq_entry_t           rd_1;
  fq_entry_t           rd_2;

  assign in_ready = count <= (PTR_W+1)'(DEPTH - 2);

  // A beat in a flush cycle is stale and must not land in the storage.
  assign enq     = in_valid && in_ok_1 && in_ready && !flush;
  assign enq_2   = enq && in_ok_2;
  assign enq_n   = {1'b0, enq} + {1'b0, enq_2};

  assign deq_req = (deq_num == 2'd3) ? 2'd2 : deq_num;
  assign deq_eff = (count < (PTR_W+1)'(deq_req)) ? count[1:0] : deq_req;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PTR_W'(enq_n);
      rptr  <= rptr + PTR_W'(deq_eff);
      count <= count + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      a_no_beat_when_full: assert (!(in_valid && !in_ready));
      a_deq_within_valid:  assert (deq_num <= 2'(out_valid_1) + 2'(out_valid_2));
    end
  end

  inst_fq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_1    (enq),
    .waddr_1 (wptr),
    .wdata_1 ({in_pc, in_inst_1}),
    .we_2    (enq_2),
    .waddr_2 (wptr + PTR_W'(1)),
    .wdata_2 ({in_pc + 32'(PC_STEP), in_inst_2}),
    .raddr_1 (rptr),
    .raddr_2 (rptr + PTR_W'(1)),
    .rdata_1 (rdata_1),
    .rdata_2 (rdata_2)
  );

  assign rd_1 = rdata_1;
  assign rd_2 = rdata_2;

  assign out_valid_1 = count >= (PTR_W+1)'(1);
  assign out_valid_2 = count >= (PTR_W+1)'(2);
  assign out_pc_1    = out_valid_1 ? rd_1.pc   : '0;
  assign out_inst_1  = out_valid_1 ? rd_1.inst : '0;
  assign out_pc_2    = out_valid_2 ? rd_2.pc   : '0;
  assign out_inst_2  = out_valid_2 ? rd_2.inst : '0;

`ifdef INST_FETCH_QUEUE_PERF_EN
  // Counters survive flush so a whole run can be profiled; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cycles  <= '0;
      perf_empty_cycles <= '0;
    end else begin
      if (!in_ready && (perf_full_cycles != 32'hFFFF_FFFF))
        perf_full_cycles <= perf_full_cycles + 32'd1;
      if ((count == '0) && !flush && (perf_empty_cycles != 32'hFFFF_FFFF))
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised self-checking bench for inst_fetch_queue against a queue-based model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ok_1;
  logic              in_ok_2;
  logic [31:0]       in_pc;
  logic [31:0]       in_inst_1;
  logic [31:0]       in_inst_2;
  logic              in_ready;
  logic              out_valid_1;
  logic              out_valid_2;
  logic [31:0]       out_pc_1;
  logic [31:0]       out_pc_2;
  logic [31:0]       out_inst_1;
  logic [31:0]       out_inst_2;
  logic [1:0]        deq_num;
  logic [PTR_W:0]    count;
`ifdef INST_FETCH_QUEUE_PERF_EN
  logic [31:0]       perf_full_cycles;
  logic [31:0]       perf_empty_cycles;
  logic [31:0]       m_full;
  logic [31:0]       m_empty;
`endif

  logic [63:0] mq[$];
  int          tests;
  int          fails;
  bit          chk_on;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ok_1     (in_ok_1),
    .in_ok_2     (in_ok_2),
    .in_pc       (in_pc),
    .in_inst_1   (in_inst_1),
    .in_inst_2   (in_inst_2),
    .in_ready    (in_ready),
    .out_valid_1 (out_valid_1),
    .out_valid_2 (out_valid_2),
    .out_pc_1    (out_pc_1),
    .out_pc_2    (out_pc_2),
    .out_inst_1  (out_inst_1),
    .out_inst_2  (out_inst_2),
    .deq_num     (deq_num),
    .count       (count)
`ifdef INST_FETCH_QUEUE_PERF_EN
    ,
    .perf_full_cycles  (perf_full_cycles),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit o1, input bit o2, input logic [31:0] pc,
                       input logic [31:0] i1, input logic [31:0] i2,
                       input logic [1:0] dq, input bit fl);
    in_valid  = v;
    in_ok_1   = o1;
    in_ok_2   = o2;
    in_pc     = pc;
    in_inst_1 = i1;
    in_inst_2 = i2;
    deq_num   = dq;
    flush     = fl;
  endtask

  task automatic idle(input logic [1:0] dq);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, dq, 1'b0);
  endtask

  // Advance one clock: update the model at the edge, compare on the falling edge.
  task automatic tick();
    int  deq;
    bit  ready_m;
    @(posedge clk);
    ready_m = (DEPTH - mq.size()) >= 2;
`ifdef INST_FETCH_QUEUE_PERF_EN
    if (rst) begin
      m_full  = 0;
      m_empty = 0;
    end else begin
      if (!ready_m && m_full != 32'hFFFF_FFFF) m_full++;
      if (mq.size() == 0 && !flush && m_empty != 32'hFFFF_FFFF) m_empty++;
    end
`endif
    if (rst || flush) begin
      mq.delete();
    end else begin
      deq = (deq_num == 2'd3) ? 2 : int'(deq_num);
      if (deq > mq.size()) deq = mq.size();
      repeat (deq) void'(mq.pop_front());
      if (in_valid && in_ok_1 && ready_m) begin
        mq.push_back({in_pc, in_inst_1});
        if (in_ok_2) mq.push_back({in_pc + 32'd4, in_inst_2});
      end
    end
    if (rst) chk_on = 1'b1;
    @(negedge clk);
    if (chk_on) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("in_ready", 32'(in_ready), 32'((DEPTH - mq.size()) >= 2));
      chk("out_valid_1", 32'(out_valid_1), 32'(mq.size() >= 1));
      chk("out_valid_2", 32'(out_valid_2), 32'(mq.size() >= 2));
      chk("out_pc_1", out_pc_1, (mq.size() >= 1) ? mq[0][63:32] : 32'h0);
      chk("out_inst_1", out_inst_1, (mq.size() >= 1) ? mq[0][31:0] : 32'h0);
      chk("out_pc_2", out_pc_2, (mq.size() >= 2) ? mq[1][63:32] : 32'h0);
      chk("out_inst_2", out_inst_2, (mq.size() >= 2) ? mq[1][31:0] : 32'h0);
`ifdef INST_FETCH_QUEUE_PERF_EN
      chk("perf_full", perf_full_cycles, m_full);
      chk("perf_empty", perf_empty_cycles, m_empty);
`endif
    end
  endtask

  initial begin
    int  mx;
    bit  slow;
    tests  = 0;
    fails  = 0;
    chk_on = 1'b0;
    rst    = 1'b1;
    idle(2'd0);

    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid_1", 32'(out_valid_1), 32'd0);
    chk("rst_pc_1", out_pc_1, 32'd0);

    // Four dual beats, nothing consumed.
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 1'b1, 1'b1, 32'hBFC0_0000 + 32'(8 * b), 32'h1000_0000 + 32'(b),
            32'h2000_0000 + 32'(b), 2'd0, 1'b0);
      tick();
    end
    chk("a_count", 32'(count), 32'd8);
    chk("a_pc_1", out_pc_1, 32'hBFC0_0000);
    chk("a_pc_2", out_pc_2, 32'hBFC0_0004);
    chk("a_ready", 32'(in_ready), 32'd1);

    // Fill to exactly DEPTH.
    for (int b = 4; b < 8; b++) begin
      drive(1'b1, 1'b1, 1'b1, 32'hBFC0_0000 + 32'(8 * b), 32'h1000_0000 + 32'(b),
            32'h2000_0000 + 32'(b), 2'd0, 1'b0);
      tick();
      if (b == 6) begin
        chk("b7_count", 32'(count), 32'd14);
        chk("b7_ready", 32'(in_ready), 32'd1);
      end
    end
    chk("b8_count", 32'(count), 32'd16);
    chk("b8_ready", 32'(in_ready), 32'd0);
    idle(2'd0);
    repeat (4) tick();
    idle(2'd2);
    tick();
    chk("b_deq_count", 32'(count), 32'd14);
    chk("b_deq_ready", 32'(in_ready), 32'd1);
    chk("b_deq_pc_1", out_pc_1, 32'hBFC0_0008);
    tick();
    tick();
    chk("b_ten", 32'(count), 32'd10);

    // Flush overrides a same-cycle beat and dequeue.
    drive(1'b1, 1'b1, 1'b1, 32'h1234_0000, 32'h1, 32'h2, 2'd2, 1'b1);
    tick();
    chk("f_count", 32'(count), 32'd0);
    chk("f_valid_1", 32'(out_valid_1), 32'd0);
    chk("f_pc_1", out_pc_1, 32'd0);
    chk("f_ready", 32'(in_ready), 32'd1);
    idle(2'd0);
    repeat (3) tick();

    // Single beats drained one per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h8000_0000 + 32'(4 * i), 32'h3000_0000 + 32'(i),
            32'hDEAD_BEEF, (mq.size() >= 1) ? 2'd1 : 2'd0, 1'b0);
      tick();
      chk("s_count", 32'(count), 32'd1);
      chk("s_pc_1", out_pc_1, 32'h8000_0000 + 32'(4 * i));
    end

    // Walk both pointers to DEPTH-1, then straddle the wrap with a dual beat.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b1);
    tick();
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h8800_0000 + 32'(4 * i), 32'h4000_0000 + 32'(i),
            32'h0, (mq.size() >= 1) ? 2'd1 : 2'd0, 1'b0);
      tick();
    end
    idle(2'd1);
    tick();
    chk("w_empty", 32'(count), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h9000_0000, 32'hAAAA_0000, 32'hBBBB_0000, 2'd0, 1'b0);
    tick();
    chk("w_inst_1", out_inst_1, 32'hAAAA_0000);
    chk("w_inst_2", out_inst_2, 32'hBBBB_0000);
    chk("w_pc_2", out_pc_2, 32'h9000_0004);
    idle(2'd2);
    tick();
    chk("w_drained", 32'(count), 32'd0);

    // Randomised phase alternating fill-heavy and drain-heavy windows.
    for (int i = 0; i < 3000; i++) begin
      slow = ((i / 150) % 2) == 0;
      mx   = (mq.size() >= 2) ? 2 : mq.size();
      rst   = ($urandom % 600) == 0;
      flush = ($urandom % 60) == 0;
      in_valid  = ((DEPTH - mq.size()) >= 2) && (($urandom % 4) != 0);
      in_ok_1   = ($urandom % 8) != 0;
      in_ok_2   = ($urandom % 3) != 0;
      in_pc     = $urandom & 32'hFFFF_FFFC;
      in_inst_1 = $urandom;
      in_inst_2 = $urandom;
      if (slow && ($urandom % 4) != 0) deq_num = 2'd0;
      else deq_num = 2'($urandom_range(0, mx));
      tick();
    end
    rst = 1'b0;
    idle(2'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
